// File: rtl/from_serial.sv
// from_serial: reassembles BW_IN-bit digit-serial chunks into BW_OUT-bit words, all channels in lockstep.
// Latency: 1 cycle from the final chunk of a word to the vld_out pulse.
// Backpressure: none; downstream must take every vld_out pulse, and vld_in is always accepted.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   vld_in   data_in carries a chunk this cycle
//   sync_in  (with vld_in) chunk is chunk 0 of a new word; discards any partial word
//   data_in  chunk for channel i at [i*BW_IN +: BW_IN]
//   vld_out  one-cycle pulse, data_out holds a freshly completed word
//   data_out word for channel i at [i*BW_OUT +: BW_OUT], held until the next completion
//   err_out  one-cycle pulse, a partial word was dropped because of sync_in
//
// BW_OUT must be an integer multiple of BW_IN.
module from_serial #(
  parameter int NO_CH     = 64,
  parameter int BW_IN     = 4,
  parameter int BW_OUT    = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vld_in,
  input  logic                    sync_in,
  input  logic [NO_CH*BW_IN-1:0]  data_in,
  output logic                    vld_out,
  output logic [NO_CH*BW_OUT-1:0] data_out,
  output logic                    err_out
);

  localparam int SER_CYC = BW_OUT / BW_IN;
  localparam int CW      = (SER_CYC > 1) ? $clog2(SER_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(SER_CYC - 1);

  // Chunk counter: index of the chunk expected next.
  logic [CW-1:0] cnt_q, cnt_d;

  // Accumulator. Never cleared between words: every position is rewritten
  // before the word can complete, so stale bits never leak out.
  logic [NO_CH*BW_OUT-1:0] acc_q, acc_d;

  logic [NO_CH*BW_OUT-1:0] data_out_q, data_out_d;
  logic                    vld_out_q, vld_out_d;
  logic                    err_out_q, err_out_d;

  logic [CW-1:0] k;     // effective chunk index of the incoming chunk
  logic [CW-1:0] pos;   // chunk slot inside the word that receives it
  logic          done;  // incoming chunk completes a word

  always_comb begin
    // sync_in forces the chunk to be chunk 0 regardless of where we were.
    k    = sync_in ? '0 : cnt_q;
    pos  = MSB_FIRST ? (LAST - k) : k;
    done = vld_in && (k == LAST);
  end

  // Merge the incoming chunk into the accumulator. acc_d is also what gets
  // captured into data_out on completion, so the final chunk is included
  // without waiting for acc_q to update.
  always_comb begin
    acc_d = acc_q;
    if (vld_in) begin
      for (int ch = 0; ch < NO_CH; ch++) begin
        for (int s = 0; s < SER_CYC; s++) begin
          if (pos == CW'(s)) begin
            acc_d[ch*BW_OUT + s*BW_IN +: BW_IN] = data_in[ch*BW_IN +: BW_IN];
          end
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (vld_in) begin
      cnt_d = (k == LAST) ? '0 : (k + CW'(1));
    end
  end

  always_comb begin
    data_out_d = done ? acc_d : data_out_q;
    vld_out_d  = done;
    // A sync while mid-word drops the partial word. With SER_CYC==1 the
    // counter is stuck at 0, so this can never fire.
    err_out_d  = vld_in && sync_in && (cnt_q != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      data_out_q <= '0;
      vld_out_q  <= 1'b0;
      err_out_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      data_out_q <= data_out_d;
      vld_out_q  <= vld_out_d;
      err_out_q  <= err_out_d;
    end
  end

  assign vld_out  = vld_out_q;
  assign data_out = data_out_q;
  assign err_out  = err_out_q;

endmodule

// File: tb/tb_from_serial.sv
module tb_from_serial;

  localparam int SER = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Main instance: 2 channels, 4-bit chunks, 16-bit words, LSB chunk first.
  logic        vld_in, sync_in, vld_out, err_out;
  logic [7:0]  data_in;
  logic [31:0] data_out;

  // MSB-first instance.
  logic        m_vld_in, m_sync_in, m_vld_out, m_err_out;
  logic [7:0]  m_data_in;
  logic [31:0] m_data_out;

  // SER_CYC==1 instance: 1 channel, 16-bit in, 16-bit out.
  logic        p_vld_in, p_sync_in, p_vld_out, p_err_out;
  logic [15:0] p_data_in, p_data_out;

  from_serial #(.NO_CH(2), .BW_IN(4), .BW_OUT(16), .MSB_FIRST(1'b0)) u_dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .sync_in(sync_in), .data_in(data_in),
    .vld_out(vld_out), .data_out(data_out), .err_out(err_out));

  from_serial #(.NO_CH(2), .BW_IN(4), .BW_OUT(16), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .vld_in(m_vld_in), .sync_in(m_sync_in), .data_in(m_data_in),
    .vld_out(m_vld_out), .data_out(m_data_out), .err_out(m_err_out));

  from_serial #(.NO_CH(1), .BW_IN(16), .BW_OUT(16), .MSB_FIRST(1'b0)) u_pass (
    .clk(clk), .rst(rst), .vld_in(p_vld_in), .sync_in(p_sync_in), .data_in(p_data_in),
    .vld_out(p_vld_out), .data_out(p_data_out), .err_out(p_err_out));

  int n_tests;
  int n_fail;

  // Reference model for the main instance: the chunks of the word in
  // progress, in arrival order ({ch1, ch0} per entry).
  logic [7:0]  parts[$];
  logic [31:0] exp_dat;
  logic        exp_vld, exp_err;

  // Drive one cycle on the main instance, predict its outputs, then sample
  // 1 time unit after the rising edge.
  task automatic step(input logic v, input logic s, input logic [3:0] c0, input logic [3:0] c1);
    logic [31:0] w;
    vld_in  = v;
    sync_in = s;
    data_in = {c1, c0};
    exp_vld = 1'b0;
    exp_err = 1'b0;
    if (v) begin
      if (s && parts.size() != 0) begin
        exp_err = 1'b1;
        parts.delete();
      end
      parts.push_back({c1, c0});
      if (parts.size() == SER) begin
        w = '0;
        for (int j = 0; j < SER; j++) begin
          w[15:0]  = w[15:0]  | (16'(parts[j][3:0]) << (4 * j));
          w[31:16] = w[31:16] | (16'(parts[j][7:4]) << (4 * j));
        end
        exp_dat = w;
        exp_vld = 1'b1;
        parts.delete();
      end
    end
    @(posedge clk);
    #1;
    vld_in  = 1'b0;
    sync_in = 1'b0;
  endtask

  task automatic model_reset();
    parts.delete();
    exp_dat = '0;
    exp_vld = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if ({vld_out, err_out, data_out} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_main: got vld=%b err=%b data=%h, want all zero", vld_out, err_out, data_out);
    end
    n_tests++;
    if ({m_vld_out, m_err_out, m_data_out, p_vld_out, p_err_out, p_data_out} !== 52'd0) begin
      n_fail++;
      $display("FAIL reset_aux: got msb %b/%b/%h pass %b/%b/%h, want all zero",
               m_vld_out, m_err_out, m_data_out, p_vld_out, p_err_out, p_data_out);
    end
    rst = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 4'h0, 4'h0);
    n_tests++;
    if ({vld_out, err_out, data_out} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got vld=%b err=%b data=%h, want all zero", vld_out, err_out, data_out);
    end
  endtask

  task automatic test_basic();
    logic [3:0] c0 [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    logic [3:0] c1 [4] = '{4'hF, 4'hE, 4'hD, 4'hC};
    for (int j = 0; j < 4; j++) begin
      step(1'b1, 1'b0, c0[j], c1[j]);
      n_tests++;
      if ({vld_out, err_out, data_out} !== {exp_vld, exp_err, exp_dat}) begin
        n_fail++;
        $display("FAIL basic[%0d]: got vld/err/data %b/%b/%h want %b/%b/%h",
                 j, vld_out, err_out, data_out, exp_vld, exp_err, exp_dat);
      end
    end
    n_tests++;
    if (vld_out !== 1'b1 || data_out !== 32'hCDEF1234) begin
      n_fail++;
      $display("FAIL basic_word: got vld=%b data=%h want 1/cdef1234", vld_out, data_out);
    end
    step(1'b0, 1'b0, 4'h0, 4'h0);
    n_tests++;
    if (vld_out !== 1'b0 || data_out !== 32'hCDEF1234) begin
      n_fail++;
      $display("FAIL basic_pulse: got vld=%b data=%h want 0/cdef1234", vld_out, data_out);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] c0 [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    logic [3:0] c1 [4] = '{4'hF, 4'hE, 4'hD, 4'hC};
    int pulses = 0;
    for (int j = 0; j < 4; j++) begin
      step(1'b1, 1'b0, c0[j], c1[j]);
      pulses += int'(vld_out);
      n_tests++;
      if ({vld_out, err_out, data_out} !== {exp_vld, exp_err, exp_dat}) begin
        n_fail++;
        $display("FAIL gaps[%0d]: got vld/err/data %b/%b/%h want %b/%b/%h",
                 j, vld_out, err_out, data_out, exp_vld, exp_err, exp_dat);
      end
      for (int g = 0; g < 3; g++) begin
        step(1'b0, 1'b0, 4'($urandom), 4'($urandom));
        pulses += int'(vld_out);
        n_tests++;
        if ({vld_out, err_out, data_out} !== {exp_vld, exp_err, exp_dat}) begin
          n_fail++;
          $display("FAIL gaps_idle[%0d.%0d]: got vld/err/data %b/%b/%h want %b/%b/%h",
                   j, g, vld_out, err_out, data_out, exp_vld, exp_err, exp_dat);
        end
      end
    end
    n_tests++;
    if (pulses != 1 || data_out !== 32'hCDEF1234) begin
      n_fail++;
      $display("FAIL gaps_word: got pulses=%0d data=%h want 1/cdef1234", pulses, data_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w0 [3] = '{16'h1234, 16'hABCD, 16'h0001};
    logic [15:0] w1 [3] = '{16'h5A5A, 16'hC3C3, 16'hFFFF};
    for (int n = 0; n < 3; n++) begin
      for (int j = 0; j < 4; j++) begin
        step(1'b1, 1'b0, w0[n][4*j +: 4], w1[n][4*j +: 4]);
        n_tests++;
        if ({vld_out, err_out, data_out} !== {exp_vld, exp_err, exp_dat}) begin
          n_fail++;
          $display("FAIL b2b[%0d.%0d]: got vld/err/data %b/%b/%h want %b/%b/%h",
                   n, j, vld_out, err_out, data_out, exp_vld, exp_err, exp_dat);
        end
      end
      n_tests++;
      if (vld_out !== 1'b1 || data_out !== {w1[n], w0[n]}) begin
        n_fail++;
        $display("FAIL b2b_word[%0d]: got vld=%b data=%h want 1/%h", n, vld_out, data_out, {w1[n], w0[n]});
      end
    end
  endtask

  task automatic test_sync_err();
    logic [3:0] c0 [6] = '{4'h4, 4'h3, 4'h8, 4'h7, 4'h6, 4'h5};
    logic       sy [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int j = 0; j < 6; j++) begin
      step(1'b1, sy[j], c0[j], 4'($urandom));
      n_tests++;
      if ({vld_out, err_out, data_out} !== {exp_vld, exp_err, exp_dat}) begin
        n_fail++;
        $display("FAIL sync[%0d]: got vld/err/data %b/%b/%h want %b/%b/%h",
                 j, vld_out, err_out, data_out, exp_vld, exp_err, exp_dat);
      end
      if (j == 2) begin
        n_tests++;
        if (err_out !== 1'b1 || vld_out !== 1'b0) begin
          n_fail++;
          $display("FAIL sync_err: got err=%b vld=%b want 1/0", err_out, vld_out);
        end
      end
    end
    n_tests++;
    if (vld_out !== 1'b1 || err_out !== 1'b0 || data_out[15:0] !== 16'h5678) begin
      n_fail++;
      $display("FAIL sync_word: got vld=%b err=%b ch0=%h want 1/0/5678", vld_out, err_out, data_out[15:0]);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0, 4'h9, 4'h9);
    step(1'b1, 1'b0, 4'h9, 4'h9);
    #3;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({vld_out, err_out, data_out} !== 34'd0) begin
      n_fail++;
      $display("FAIL async_reset: got vld=%b err=%b data=%h want all zero", vld_out, err_out, data_out);
    end
    #2;
    rst = 1'b1;
    model_reset();
    for (int j = 0; j < 4; j++) begin
      step(1'b1, 1'b0, 4'(4 - j), 4'($urandom));
      n_tests++;
      if ({vld_out, err_out, data_out} !== {exp_vld, exp_err, exp_dat}) begin
        n_fail++;
        $display("FAIL post_reset[%0d]: got vld/err/data %b/%b/%h want %b/%b/%h",
                 j, vld_out, err_out, data_out, exp_vld, exp_err, exp_dat);
      end
    end
    n_tests++;
    if (vld_out !== 1'b1 || err_out !== 1'b0 || data_out[15:0] !== 16'h1234) begin
      n_fail++;
      $display("FAIL post_reset_word: got vld=%b err=%b ch0=%h want 1/0/1234", vld_out, err_out, data_out[15:0]);
    end
  endtask

  task automatic test_msb_first();
    logic [15:0] w0, w1;
    for (int r = 0; r < 4; r++) begin
      if (r == 0) begin
        w0 = 16'h1234;
        w1 = 16'hABCD;
      end else begin
        w0 = 16'($urandom);
        w1 = 16'($urandom);
      end
      for (int j = 0; j < 4; j++) begin
        m_vld_in  = 1'b1;
        m_sync_in = (j == 0);
        m_data_in = {w1[15-4*j -: 4], w0[15-4*j -: 4]};
        @(posedge clk);
        #1;
        m_vld_in  = 1'b0;
        m_sync_in = 1'b0;
        n_tests++;
        if (j < 3) begin
          if (m_vld_out !== 1'b0 || m_err_out !== 1'b0) begin
            n_fail++;
            $display("FAIL msb[%0d.%0d]: got vld=%b err=%b want 0/0", r, j, m_vld_out, m_err_out);
          end
        end else if (m_vld_out !== 1'b1 || m_err_out !== 1'b0 || m_data_out !== {w1, w0}) begin
          n_fail++;
          $display("FAIL msb_word[%0d]: got vld=%b err=%b data=%h want 1/0/%h",
                   r, m_vld_out, m_err_out, m_data_out, {w1, w0});
        end
      end
    end
  endtask

  task automatic test_passthru();
    logic [15:0] d;
    logic [15:0] last;
    for (int r = 0; r < 6; r++) begin
      d = (r == 0) ? 16'hBEEF : 16'($urandom);
      p_vld_in  = 1'b1;
      p_sync_in = (r == 0) ? 1'b0 : 1'($urandom);
      p_data_in = d;
      @(posedge clk);
      #1;
      p_vld_in  = 1'b0;
      p_sync_in = 1'b0;
      last = d;
      n_tests++;
      if (p_vld_out !== 1'b1 || p_err_out !== 1'b0 || p_data_out !== d) begin
        n_fail++;
        $display("FAIL pass[%0d]: got vld=%b err=%b data=%h want 1/0/%h", r, p_vld_out, p_err_out, p_data_out, d);
      end
    end
    p_data_in = 16'($urandom);
    @(posedge clk);
    #1;
    n_tests++;
    if (p_vld_out !== 1'b0 || p_err_out !== 1'b0 || p_data_out !== last) begin
      n_fail++;
      $display("FAIL pass_hold: got vld=%b err=%b data=%h want 0/0/%h", p_vld_out, p_err_out, p_data_out, last);
    end
  endtask

  task automatic test_random();
    logic v, s;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 9) == 0);
      step(v, s, 4'($urandom), 4'($urandom));
      n_tests++;
      if ({vld_out, err_out, data_out} !== {exp_vld, exp_err, exp_dat}) begin
        n_fail++;
        $display("FAIL random[%0d]: got vld/err/data %b/%b/%h want %b/%b/%h",
                 i, vld_out, err_out, data_out, exp_vld, exp_err, exp_dat);
      end
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b0;
    vld_in    = 1'b0;
    sync_in   = 1'b0;
    data_in   = '0;
    m_vld_in  = 1'b0;
    m_sync_in = 1'b0;
    m_data_in = '0;
    p_vld_in  = 1'b0;
    p_sync_in = 1'b0;
    p_data_in = '0;
    model_reset();

    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_sync_err();
    test_async_reset();
    test_msb_first();
    test_passthru();
    test_random();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/from_serial.md
Name: from_serial

Overview:
- Deserializer: the receive-side counterpart of to_serial. It collects BW_IN-bit digit-serial chunks per channel and reassembles them into full BW_OUT-bit parallel words.
- Sits after a serial conv/maxpool stage wherever a later stage needs full-width words, for example parallel bn_relu_fp or a dense-layer flatten.
- All NO_CH channels advance in lockstep. One parallel word per channel is emitted every SER_CYC = BW_OUT/BW_IN accepted chunks.

Parameters:
- NO_CH, 64, number of parallel channels.
- BW_IN, 4, serial chunk width per channel. BW_OUT must be an integer multiple of BW_IN.
- BW_OUT, 16, reassembled word width per channel.
- MSB_FIRST, 0, chunk order. 0 means the first chunk is the least-significant chunk, matching to_serial. 1 means the first chunk is the most-significant chunk.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- vld_in  in  1  data_in holds a valid chunk this cycle.
- sync_in  in  1  qualified by vld_in. Marks the chunk as chunk 0 of a new word.
- data_in  in  NO_CH*BW_IN  chunk for channel i at [i*BW_IN +: BW_IN].
- vld_out  out  1  one-cycle pulse: data_out holds a new word.
- data_out  out  NO_CH*BW_OUT  word for channel i at [i*BW_OUT +: BW_OUT].
- err_out  out  1  one-cycle pulse: a partial word was discarded by sync_in.

Behaviour:
- Reset (rst=0, asynchronous assert):
  - cnt=0, shift register=0, data_out=0, vld_out=0, err_out=0.
  - Release is synchronous to clk. The first vld_in accepted after release is chunk 0.
- Internal state:
  - cnt, width max(1, clog2(SER_CYC)), range 0..SER_CYC-1.
  - Accumulation register acc, NO_CH*BW_OUT bits.
- Accept (vld_in=1): the effective index is k = (sync_in ? 0 : cnt).
  - MSB_FIRST=0: the chunk is written to acc bits [k*BW_IN +: BW_IN] of each channel.
  - MSB_FIRST=1: the chunk is written to acc bits [(SER_CYC-1-k)*BW_IN +: BW_IN].
  - Chunks at other positions are unchanged.
- Counter update:
  - If k==SER_CYC-1, cnt becomes 0. Otherwise cnt becomes k+1.
  - vld_in=0 means cnt and acc hold. Gaps of any length between chunks are legal.
- Completion: when a chunk with k==SER_CYC-1 is accepted, on the next edge:
  - data_out is loaded with the full assembled word, with the final chunk merged combinationally (not read from the stale acc).
  - vld_out=1 for exactly one cycle.
  - Latency: 1 cycle from the last chunk to vld_out.
- data_out holds its value until the next completion and is never cleared except by reset.
- Back-to-back words with no gap: throughput is one word per SER_CYC cycles. The chunk after a completion is chunk 0 of the next word, in the same cycle vld_out is high.
- sync_in=1 with vld_in=1 while cnt!=0:
  - The partial word is discarded and the chunk is taken as chunk 0.
  - err_out=1 on the next cycle for one cycle. vld_out is not asserted for the discarded word.
- sync_in=1 while cnt==0: normal operation, no error.
- sync_in with vld_in=0: ignored.
- SER_CYC==1: every valid chunk produces vld_out on the next cycle with data_out=data_in (a registered pass-through). sync_in never errors.
- Stale chunk bits in acc are always overwritten before completion, so acc is never cleared between words.
- No sign extension or arithmetic. Bits are reassembled verbatim.
- No backpressure. The downstream must accept every vld_out pulse.

Test Plan:
- NO_CH=2, BW_IN=4, BW_OUT=16, MSB_FIRST=0. Drive ch0 chunks 4,3,2,1 and ch1 chunks F,E,D,C on 4 consecutive cycles -> one cycle after the 4th chunk: vld_out=1 for 1 cycle, ch0=16'h1234, ch1=16'hCDEF.
- Same data with 3 idle cycles inserted between each chunk -> identical data_out; vld_out pulses once, 1 cycle after the final chunk.
- Three words streamed back-to-back (12 consecutive valid cycles): 16'h1234, 16'hABCD, 16'h0001 -> vld_out on cycles 5, 9, 13 after the first chunk with the matching data; data_out held between pulses.
- Chunks 4,3 then sync_in with 8,7,6,5 -> err_out=1 for 1 cycle after the sync chunk; next vld_out gives 16'h5678; the partial word is never output.
- rst=0 asserted asynchronously mid-clock after 2 chunks -> outputs zero immediately without a clock edge. After release, chunks 4,3,2,1 give 16'h1234 with no err_out.
- MSB_FIRST=1, chunks 1,2,3,4 -> 16'h1234. SER_CYC=1 (BW_IN=BW_OUT=16) with input 16'hBEEF -> data_out=16'hBEEF and vld_out on the next cycle.
